// File: rtl/lane_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lane_hazard_ctrl
// Purpose  : Scrolls N independent hazard lanes (logs/cars) horizontally
//            across the game grid. Each lane has its own direction and
//            step period (shared base period plus a per-lane skew). The
//            shared base period shortens on every level-up down to a floor.
//            Lanes can be paused and restarted. Publishes packed lane X/Y
//            positions and one-cycle step pulses that let the player ride
//            floating elements.
// Revision : 1.0 - initial release
// ============================================================================
module lane_hazard_ctrl #(
    parameter int                     c_NUM_LANES    = 4,
    parameter int                     c_GRID_W       = 14,
    parameter int                     c_LANE_Y_BASE  = 5,
    parameter int                     c_INIT_X       = 13,
    parameter int                     c_INIT_SPACING = 3,
    parameter logic [c_NUM_LANES-1:0] c_DIR_MASK     = 4'b1010,
    parameter int                     c_BASE_COUNT   = 4000000,
    parameter int                     c_LANE_SKEW    = 500000,
    parameter int                     c_STEP_COUNT   = 250000,
    parameter int                     c_MIN_COUNT    = 1000000
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic                       i_Enable,
    input  logic                       i_Restart,
    input  logic                       i_Level_Up,
    output logic [6*c_NUM_LANES-1:0]   o_Lane_X,
    output logic [6*c_NUM_LANES-1:0]   o_Lane_Y,
    output logic [c_NUM_LANES-1:0]     o_Lane_Step,
    output logic [3:0]                 o_Level
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [31:0] c_BASE_PERIOD = 32'(c_BASE_COUNT);
    localparam logic [31:0] c_PERIOD_DEC  = 32'(c_STEP_COUNT);
    localparam logic [31:0] c_PERIOD_MIN  = 32'(c_MIN_COUNT);
    localparam logic [3:0]  c_LEVEL_MAX   = 4'd15;
    localparam logic [5:0]  c_X_MAX       = 6'(c_GRID_W - 1);

    // ------------------------------------------------------------------------
    // Shared speed state
    // ------------------------------------------------------------------------
    logic [31:0] r_period;
    logic [3:0]  r_level;
    logic [31:0] w_period_next;

    // Next base period after a level-up: subtract the decrement, but never
    // go below the floor. Compare in 33 bits so floor + decrement cannot wrap.
    always_comb begin
        w_period_next = c_PERIOD_MIN;
        if ({1'b0, r_period} >= ({1'b0, c_PERIOD_MIN} + {1'b0, c_PERIOD_DEC})) begin
            w_period_next = r_period - c_PERIOD_DEC;
        end
    end

    // Base period and level register; level-up is honoured even while paused
    // or restarting, only a full reset overrides it.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_period <= c_BASE_PERIOD;
            r_level  <= 4'd0;
        end else if (i_Level_Up) begin
            r_period <= w_period_next;
            if (r_level != c_LEVEL_MAX) begin
                r_level <= r_level + 4'd1;
            end
        end
    end

    assign o_Level = r_level;

    // ------------------------------------------------------------------------
    // Per-lane position engines
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_NUM_LANES; i++) begin : g_lane
            localparam logic [5:0]  c_START_X   = 6'((c_INIT_X + i * c_INIT_SPACING) % c_GRID_W);
            localparam logic [5:0]  c_Y         = 6'(c_LANE_Y_BASE + i);
            localparam logic [31:0] c_SKEW      = 32'(i * c_LANE_SKEW);
            localparam logic        c_DIR_RIGHT = c_DIR_MASK[i];

            logic [31:0] r_cnt;
            logic [5:0]  r_x;
            logic        r_step;
            logic [31:0] w_lane_period;
            logic        w_due;
            logic [5:0]  w_next_x;

            // Lane period follows the live base period, so a step due in the
            // same cycle as a level-up is judged against the old period. The
            // >= compare lets a counter already past a shortened period step
            // on its next enabled cycle instead of running on to wrap.
            always_comb begin
                w_lane_period = r_period + c_SKEW;
                w_due         = (r_cnt >= (w_lane_period - 32'd1));
            end

            // One-cell move with wrap-around; positions outside the grid are
            // pulled back onto a legal cell so nothing illegal is ever output.
            always_comb begin
                w_next_x = r_x;
                if (c_DIR_RIGHT) begin
                    if (r_x >= c_X_MAX) begin
                        w_next_x = 6'd0;
                    end else begin
                        w_next_x = r_x + 6'd1;
                    end
                end else begin
                    if (r_x == 6'd0 || r_x > c_X_MAX) begin
                        w_next_x = c_X_MAX;
                    end else begin
                        w_next_x = r_x - 6'd1;
                    end
                end
            end

            // Counter, position and step pulse; restart beats stepping, and
            // a paused lane holds its count so resuming picks up where it left.
            always_ff @(posedge i_Clk) begin
                if (i_Reset || i_Restart) begin
                    r_cnt  <= 32'd0;
                    r_x    <= c_START_X;
                    r_step <= 1'b0;
                end else if (i_Enable) begin
                    if (w_due) begin
                        r_cnt  <= 32'd0;
                        r_x    <= w_next_x;
                        r_step <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 32'd1;
                        r_step <= 1'b0;
                    end
                end else begin
                    r_step <= 1'b0;
                end
            end

            assign o_Lane_X[6*i +: 6] = r_x;
            assign o_Lane_Y[6*i +: 6] = c_Y;
            assign o_Lane_Step[i]     = r_step;
        end
    endgenerate

endmodule
`default_nettype wire
